bg_remove_engine: RTL

// Streaming, multi-lane successor to the single-pixel background-removal PE.

---
 rtl/bg_pkg.sv | 26 ++
 rtl/bg_lane_cmp.sv | 46 ++++
 rtl/bg_remove_engine.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bg_pkg.sv
// Shared definitions for the background-removal engine.
// Contents:
//   - default channel width, lane count and frame size
//   - FSM state encoding (one enum shared by the top level)
//   - helper that turns frame size and lane count into beats per frame
package bg_pkg;

    localparam int PIX_W_DEF    = 8;
    localparam int LANES_DEF    = 4;
    localparam int LOG2_PIX_DEF = 4;

    typedef enum logic [2:0] {
        ST_I   = 3'd0,   // idle
        ST_SI  = 3'd1,   // sum pass init
        ST_S   = 3'd2,   // sum pass streaming
        ST_SD  = 3'd3,   // sum pass done
        ST_BGI = 3'd4,   // removal pass init
        ST_BG  = 3'd5,   // removal pass streaming
        ST_BGD = 3'd6    // removal pass done
    } state_e;

    function automatic int frame_beats(input int log2_pix, input int lanes);
        return (1 << log2_pix) / lanes;
    endfunction

endpackage

// File: rtl/bg_lane_cmp.sv
// One pixel's compare/replace logic (purely combinational).
// Ports:
//   r_i/g_i/b_i          input pixel
//   exp_r_i/g_i/b_i      expected background (frame mean)
//   thr_i                per-channel tolerance
//   bg_r_i/g_i/b_i       replacement colour
//   r_o/g_o/b_o          replacement colour when every channel is within
//                        tolerance, otherwise the input pixel
module bg_lane_cmp
    import bg_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic [PIX_W-1:0] r_i,
    input  logic [PIX_W-1:0] g_i,
    input  logic [PIX_W-1:0] b_i,
    input  logic [PIX_W-1:0] exp_r_i,
    input  logic [PIX_W-1:0] exp_g_i,
    input  logic [PIX_W-1:0] exp_b_i,
    input  logic [PIX_W-1:0] thr_i,
    input  logic [PIX_W-1:0] bg_r_i,
    input  logic [PIX_W-1:0] bg_g_i,
    input  logic [PIX_W-1:0] bg_b_i,
    output logic [PIX_W-1:0] r_o,
    output logic [PIX_W-1:0] g_o,
    output logic [PIX_W-1:0] b_o
);

    // Extra bit keeps the subtraction unsigned and wrap-free.
    function automatic logic [PIX_W:0] absdiff(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
        if (a >= b) return {1'b0, a} - {1'b0, b};
        else        return {1'b0, b} - {1'b0, a};
    endfunction

    logic is_bg;

    assign is_bg = (absdiff(r_i, exp_r_i) <= {1'b0, thr_i}) &&
                   (absdiff(g_i, exp_g_i) <= {1'b0, thr_i}) &&
                   (absdiff(b_i, exp_b_i) <= {1'b0, thr_i});

    assign r_o = is_bg ? bg_r_i : r_i;
    assign g_o = is_bg ? bg_g_i : g_i;
    assign b_o = is_bg ? bg_b_i : b_i;

endmodule

// File: rtl/bg_remove_engine.sv
// Streaming multi-lane background-removal engine.
// Sum pass accumulates per-channel frame totals and derives the mean as the
// expected background; removal pass replaces pixels close to that mean with
// the desired colour.
// Ports:
//   Clk, Reset (sync, active-low)
//   Start_Sum, Start_BgRemoval, Ack        pass control
//   threshold, desired_bg_r/g/b            removal parameters
//   in_valid/in_ready, red/green/blue_in   input beat stream, LANES pixels
//   out_valid/out_ready, red/green/blue_out output beat stream (removal only)
//   red/green/blue_sum, red/green/blue_exp frame totals and means
//   Qi..Qbgd                               one-hot state flags
module bg_remove_engine
    import bg_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int LANES    = LANES_DEF,
    parameter int LOG2_PIX = LOG2_PIX_DEF
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Start_Sum,
    input  logic                      Start_BgRemoval,
    input  logic                      Ack,
    input  logic [PIX_W-1:0]          threshold,
    input  logic [PIX_W-1:0]          desired_bg_r,
    input  logic [PIX_W-1:0]          desired_bg_g,
    input  logic [PIX_W-1:0]          desired_bg_b,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PIX_W*LANES-1:0]    red_in,
    input  logic [PIX_W*LANES-1:0]    green_in,
    input  logic [PIX_W*LANES-1:0]    blue_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PIX_W*LANES-1:0]    red_out,
    output logic [PIX_W*LANES-1:0]    green_out,
    output logic [PIX_W*LANES-1:0]    blue_out,
    output logic [PIX_W+LOG2_PIX-1:0] red_sum,
    output logic [PIX_W+LOG2_PIX-1:0] green_sum,
    output logic [PIX_W+LOG2_PIX-1:0] blue_sum,
    output logic [PIX_W-1:0]          red_exp,
    output logic [PIX_W-1:0]          green_exp,
    output logic [PIX_W-1:0]          blue_exp,
    output logic                      Qi,
    output logic                      Qsi,
    output logic                      Qs,
    output logic                      Qsd,
    output logic                      Qbgi,
    output logic                      Qbg,
    output logic                      Qbgd
);

    localparam int SUM_W = PIX_W + LOG2_PIX;
    localparam int BEATS = frame_beats(LOG2_PIX, LANES);
    localparam int CNT_W = LOG2_PIX + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   last_in_q, last_in_d;   // final beat already taken in removal pass
    logic [SUM_W-1:0]       sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
    logic [PIX_W-1:0]       exp_r_q, exp_r_d, exp_g_q, exp_g_d, exp_b_q, exp_b_d;
    logic                   out_valid_q, out_valid_d;
    logic [PIX_W*LANES-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;

    logic [PIX_W*LANES-1:0] cmp_r, cmp_g, cmp_b;
    logic [SUM_W-1:0]       tot_r, tot_g, tot_b;
    logic [SUM_W-1:0]       sum_r_nx, sum_g_nx, sum_b_nx;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            bg_lane_cmp #(.PIX_W(PIX_W)) u_cmp (
                .r_i     (red_in  [gi*PIX_W +: PIX_W]),
                .g_i     (green_in[gi*PIX_W +: PIX_W]),
                .b_i     (blue_in [gi*PIX_W +: PIX_W]),
                .exp_r_i (exp_r_q),
                .exp_g_i (exp_g_q),
                .exp_b_i (exp_b_q),
                .thr_i   (threshold),
                .bg_r_i  (desired_bg_r),
                .bg_g_i  (desired_bg_g),
                .bg_b_i  (desired_bg_b),
                .r_o     (cmp_r[gi*PIX_W +: PIX_W]),
                .g_o     (cmp_g[gi*PIX_W +: PIX_W]),
                .b_o     (cmp_b[gi*PIX_W +: PIX_W])
            );
        end
    endgenerate

    // Per-beat lane totals; a frame's worth of pixels fits in SUM_W bits.
    always_comb begin
        tot_r = '0;
        tot_g = '0;
        tot_b = '0;
        for (int k = 0; k < LANES; k++) begin
            tot_r = tot_r + SUM_W'(red_in  [k*PIX_W +: PIX_W]);
            tot_g = tot_g + SUM_W'(green_in[k*PIX_W +: PIX_W]);
            tot_b = tot_b + SUM_W'(blue_in [k*PIX_W +: PIX_W]);
        end
    end

    assign sum_r_nx = sum_r_q + tot_r;
    assign sum_g_nx = sum_g_q + tot_g;
    assign sum_b_nx = sum_b_q + tot_b;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_in_d   = last_in_q;
        sum_r_d     = sum_r_q;
        sum_g_d     = sum_g_q;
        sum_b_d     = sum_b_q;
        exp_r_d     = exp_r_q;
        exp_g_d     = exp_g_q;
        exp_b_d     = exp_b_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_g_d     = out_g_q;
        out_b_d     = out_b_q;
        in_ready    = 1'b0;

        case (state_q)
            ST_I: begin
                if (Start_Sum)            state_d = ST_SI;
                else if (Start_BgRemoval) state_d = ST_BGI;
            end
            ST_SI: begin
                sum_r_d = '0;
                sum_g_d = '0;
                sum_b_d = '0;
                cnt_d   = '0;
                state_d = ST_S;
            end
            ST_S: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sum_r_d = sum_r_nx;
                    sum_g_d = sum_g_nx;
                    sum_b_d = sum_b_nx;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        // Mean uses the sum including this final beat.
                        exp_r_d = PIX_W'(sum_r_nx >> LOG2_PIX);
                        exp_g_d = PIX_W'(sum_g_nx >> LOG2_PIX);
                        exp_b_d = PIX_W'(sum_b_nx >> LOG2_PIX);
                        state_d = ST_SD;
                    end
                end
            end
            ST_SD: begin
                if (Ack) state_d = ST_I;
            end
            ST_BGI: begin
                cnt_d       = '0;
                last_in_d   = 1'b0;
                out_valid_d = 1'b0;
                state_d     = ST_BG;
            end
            ST_BG: begin
                // Stop taking beats once the frame is in; the output register
                // only needs to drain from then on.
                in_ready = !last_in_q && (!out_valid_q || out_ready);
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_in_q) state_d = ST_BGD;
                end
                if (in_ready && in_valid) begin
                    out_r_d     = cmp_r;
                    out_g_d     = cmp_g;
                    out_b_d     = cmp_b;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) last_in_d = 1'b1;
                end
            end
            ST_BGD: begin
                out_valid_d = 1'b0;
                if (Ack) state_d = ST_I;
            end
            default: state_d = ST_I;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= ST_I;
            cnt_q       <= '0;
            last_in_q   <= 1'b0;
            sum_r_q     <= '0;
            sum_g_q     <= '0;
            sum_b_q     <= '0;
            exp_r_q     <= '0;
            exp_g_q     <= '0;
            exp_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_in_q   <= last_in_d;
            sum_r_q     <= sum_r_d;
            sum_g_q     <= sum_g_d;
            sum_b_q     <= sum_b_d;
            exp_r_q     <= exp_r_d;
            exp_g_q     <= exp_g_d;
            exp_b_q     <= exp_b_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_g_q     <= out_g_d;
            out_b_q     <= out_b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign red_out   = out_r_q;
    assign green_out = out_g_q;
    assign blue_out  = out_b_q;
    assign red_sum   = sum_r_q;
    assign green_sum = sum_g_q;
    assign blue_sum  = sum_b_q;
    assign red_exp   = exp_r_q;
    assign green_exp = exp_g_q;
    assign blue_exp  = exp_b_q;

    assign Qi   = (state_q == ST_I);
    assign Qsi  = (state_q == ST_SI);
    assign Qs   = (state_q == ST_S);
    assign Qsd  = (state_q == ST_SD);
    assign Qbgi = (state_q == ST_BGI);
    assign Qbg  = (state_q == ST_BG);
    assign Qbgd = (state_q == ST_BGD);

endmodule
